// File: rtl/fir_ap_ctrl_arbiter_if.sv
// AXI-Lite control bus bundle between the host master and the FIR control front end.
interface fir_ap_ctrl_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_ap_ctrl_arbiter.sv
// FIR control front end: ap_ctrl/data_length/tap register map over AXI-Lite, tap BRAM arbitration.
// Optional feature macro FIR_CTRL_IRQ_EN adds the 0x04 irq_enable register and a live irq output.
module fir_ap_ctrl_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_ap_ctrl_arbiter_if.slave   s_axil,
  output logic                   o_ap_start,
  input  logic                   i_eng_done,
  output logic [31:0]            o_data_length,
  input  logic                   i_eng_tap_req,
  input  logic [pADDR_WIDTH-1:0] i_eng_tap_addr,
  output logic                   o_eng_tap_gnt,
  output logic [pDATA_WIDTH-1:0] o_eng_tap_do,
  output logic [3:0]             o_tap_WE,
  output logic                   o_tap_EN,
  output logic [pDATA_WIDTH-1:0] o_tap_Di,
  output logic [pADDR_WIDTH-1:0] o_tap_A,
  input  logic [pDATA_WIDTH-1:0] i_tap_Do,
  output logic                   o_irq
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RA, S_RD, S_RESP} state_t;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_IRQ  = pADDR_WIDTH'(4);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(64);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'(64 + 4*Tape_Num);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_ap_idle;
  logic                     r_ap_done;
  logic                     r_ap_start;
  logic [31:0]              r_data_length;
  logic [pADDR_WIDTH-1:0]   r_raddr;
  logic [pDATA_WIDTH-1:0]   r_rdata;
  logic                     r_rd_bram;
  logic                     w_irq_en;
  logic                     w_wr_tap;
  logic                     w_rd_tap;
  logic                     w_wr_fire;
  logic                     w_rd_fire;
  logic [pDATA_WIDTH-1:0]   w_reg_rdata;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= ADDR_TAP0) && (a < ADDR_TAPN) && (a[1:0] == 2'b00);
  endfunction

  // Tap writes while the engine runs are swallowed on the bus and never reach the BRAM.
  assign w_wr_tap = is_tap(s_axil.awaddr) && r_ap_idle;
  assign w_rd_tap = is_tap(r_raddr);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    s_axil.awready = 1'b0;
    s_axil.wready  = 1'b0;
    s_axil.arready = 1'b0;
    w_wr_fire      = 1'b0;
    w_rd_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s_axil.awvalid && s_axil.wvalid) w_state_nxt = S_WR;
        else if (s_axil.arvalid)             w_state_nxt = S_RA;
      end
      S_WR: begin
        if (!(w_wr_tap && i_eng_tap_req)) begin
          s_axil.awready = 1'b1;
          s_axil.wready  = 1'b1;
          w_wr_fire      = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      S_RA: begin
        s_axil.arready = 1'b1;
        w_state_nxt    = S_RD;
      end
      S_RD: begin
        if (!(w_rd_tap && i_eng_tap_req)) begin
          w_rd_fire   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (s_axil.rready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_raddr)
      ADDR_CTRL: w_reg_rdata = pDATA_WIDTH'({r_ap_idle, r_ap_done, 1'b0});
      ADDR_IRQ:  w_reg_rdata = pDATA_WIDTH'(w_irq_en);
      ADDR_LEN:  w_reg_rdata = pDATA_WIDTH'(r_data_length);
      default:   w_reg_rdata = '0;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_ap_idle     <= 1'b1;
      r_ap_done     <= 1'b0;
      r_ap_start    <= 1'b0;
      r_data_length <= '0;
      r_raddr       <= '0;
      r_rdata       <= '0;
      r_rd_bram     <= 1'b0;
    end else begin
      r_ap_start <= 1'b0;
      if (r_state == S_RA) r_raddr <= s_axil.araddr;
      // BRAM data arrives in the first RESP cycle; hold it so rdata stays stable under backpressure.
      if (w_rd_fire) begin
        r_rd_bram <= w_rd_tap;
        r_rdata   <= w_reg_rdata;
      end else if (r_rd_bram) begin
        r_rd_bram <= 1'b0;
        r_rdata   <= i_tap_Do;
      end
      if (w_wr_fire && r_ap_idle) begin
        if (s_axil.awaddr == ADDR_CTRL && s_axil.wdata[0]) begin
          r_ap_start <= 1'b1;
          r_ap_idle  <= 1'b0;
          r_ap_done  <= 1'b0;
        end
        if (s_axil.awaddr == ADDR_LEN) r_data_length <= s_axil.wdata[31:0];
      end
      if (r_state == S_RESP && s_axil.rready && r_raddr == ADDR_CTRL) r_ap_done <= 1'b0;
      if (i_eng_done) begin
        r_ap_done <= 1'b1;
        r_ap_idle <= 1'b1;
      end
    end
  end

`ifdef FIR_CTRL_IRQ_EN
  logic r_irq_en;
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)                                   r_irq_en <= 1'b0;
    else if (w_wr_fire && s_axil.awaddr == ADDR_IRQ)   r_irq_en <= s_axil.wdata[0];
  end
  assign w_irq_en = r_irq_en;
`else
  assign w_irq_en = 1'b0;
`endif

  assign o_irq         = r_ap_done & w_irq_en;
  assign o_ap_start    = r_ap_start;
  assign o_data_length = r_data_length;
  assign s_axil.rvalid = (r_state == S_RESP);
  assign s_axil.rdata  = r_rd_bram ? i_tap_Do : r_rdata;
  assign o_eng_tap_gnt = i_eng_tap_req;
  assign o_eng_tap_do  = i_tap_Do;

  // Engine owns the port whenever it asks; AXI only gets the cycles it leaves free.
  always_comb begin
    o_tap_EN = 1'b0;
    o_tap_WE = 4'h0;
    o_tap_A  = '0;
    o_tap_Di = '0;
    if (i_eng_tap_req) begin
      o_tap_EN = 1'b1;
      o_tap_A  = i_eng_tap_addr;
    end else if (r_state == S_WR && w_wr_tap) begin
      o_tap_EN = 1'b1;
      o_tap_WE = 4'hF;
      o_tap_A  = s_axil.awaddr - ADDR_TAP0;
      o_tap_Di = s_axil.wdata;
    end else if (r_state == S_RD && w_rd_tap) begin
      o_tap_EN = 1'b1;
      o_tap_A  = r_raddr - ADDR_TAP0;
    end
  end

endmodule

// File: tb/tb_fir_ap_ctrl_arbiter.sv
// Directed bench for fir_ap_ctrl_arbiter: register-map model, bus tasks and a per-cycle output compare.
module tb_fir_ap_ctrl_arbiter;

`ifdef FIR_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  localparam int TAP_VALS [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        eng_done;
  logic        eng_tap_req;
  logic [11:0] eng_tap_addr;
  logic        o_ap_start;
  logic [31:0] o_data_length;
  logic        o_eng_tap_gnt;
  logic [31:0] o_eng_tap_do;
  logic [3:0]  o_tap_WE;
  logic        o_tap_EN;
  logic [31:0] o_tap_Di;
  logic [11:0] o_tap_A;
  logic [31:0] tap_Do;
  logic        o_irq;
  logic [31:0] bram [0:1023];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_taps [11];
  logic [31:0] m_len;
  logic        m_idle, m_done, m_irq_en;
  int          start_set = 0;

  always #5 clk = ~clk;

  fir_ap_ctrl_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bif ();

  fir_ap_ctrl_arbiter #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk       (clk),
    .axis_rst_n     (rst_n),
    .s_axil         (bif),
    .o_ap_start     (o_ap_start),
    .i_eng_done     (eng_done),
    .o_data_length  (o_data_length),
    .i_eng_tap_req  (eng_tap_req),
    .i_eng_tap_addr (eng_tap_addr),
    .o_eng_tap_gnt  (o_eng_tap_gnt),
    .o_eng_tap_do   (o_eng_tap_do),
    .o_tap_WE       (o_tap_WE),
    .o_tap_EN       (o_tap_EN),
    .o_tap_Di       (o_tap_Di),
    .o_tap_A        (o_tap_A),
    .i_tap_Do       (tap_Do),
    .o_irq          (o_irq)
  );

  // Synchronous single-port tap BRAM, read-before-write.
  always @(posedge clk) begin
    if (o_tap_EN) begin
      if (o_tap_WE == 4'hF) bram[o_tap_A[11:2]] <= o_tap_Di;
      tap_Do <= bram[o_tap_A[11:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h000) return {29'b0, m_idle, m_done, 1'b0};
    if (a == 12'h004) return 32'(m_irq_en);
    if (a == 12'h010) return m_len;
    if (a >= 12'h040 && a < 12'h06C && a[1:0] == 2'b00) return 32'(m_taps[(a - 12'h040) >> 2]);
    return 32'h0;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h000) begin
      if (d[0] && m_idle) begin
        m_idle = 1'b0;
        m_done = 1'b0;
        start_set++;
      end
    end else if (a == 12'h004) begin
`ifdef FIR_CTRL_IRQ_EN
      m_irq_en = d[0];
`endif
    end else if (a == 12'h010) begin
      if (m_idle) m_len = d;
    end else if (a >= 12'h040 && a < 12'h06C && a[1:0] == 2'b00) begin
      if (m_idle) m_taps[(a - 12'h040) >> 2] = int'(d);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data);
    int n;
    @(posedge clk); #1;
    bif.awaddr = addr; bif.wdata = data; bif.awvalid = 1'b1; bif.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bif.awready && bif.wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(bif.awready && bif.wready)) timeout("axi_write");
    else begin
      @(posedge clk);
      model_write(addr, data);
    end
    #1;
    bif.awvalid = 1'b0; bif.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, input int hold, output logic [31:0] data);
    int n;
    data = 32'hx;
    @(posedge clk); #1;
    bif.araddr = addr; bif.arvalid = 1'b1; bif.rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bif.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bif.arready) begin
      timeout("axi_read_ar");
      #1 bif.arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bif.arvalid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bif.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bif.rvalid) begin
      timeout("axi_read_r");
      return;
    end
    check("rd_latency", 32'(n), 32'd2);
    data = bif.rdata;
    check($sformatf("rdata_model@%03h", addr), data, model_read(addr));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("rvalid_hold", 32'(bif.rvalid), 32'd1);
      check("rdata_stable", bif.rdata, data);
    end
    bif.rready = 1'b1;
    @(posedge clk);
    if (addr == 12'h000) m_done = 1'b0;
    #1 bif.rready = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    eng_done = 1'b1;
    @(posedge clk);
    m_done = 1'b1;
    m_idle = 1'b1;
    #1 eng_done = 1'b0;
  endtask

  task automatic compare_loop();
    int ack = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("data_length", o_data_length, m_len);
        check("ap_start", 32'(o_ap_start), 32'(start_set != ack));
        check("irq", 32'(o_irq), 32'(m_done & m_irq_en));
        check("eng_gnt", 32'(o_eng_tap_gnt), 32'(eng_tap_req));
        if (eng_tap_req) begin
          check("eng_tap_A", 32'(o_tap_A), 32'(eng_tap_addr));
          check("eng_tap_WE", 32'(o_tap_WE), 32'd0);
          check("eng_tap_EN", 32'(o_tap_EN), 32'd1);
        end
      end
      ack = start_set;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; eng_done = 1'b0; eng_tap_req = 1'b0; eng_tap_addr = '0;
    bif.awvalid = 1'b0; bif.awaddr = '0; bif.wvalid = 1'b0; bif.wdata = '0;
    bif.arvalid = 1'b0; bif.araddr = '0; bif.rready = 1'b0;
    m_len = '0; m_idle = 1'b1; m_done = 1'b0; m_irq_en = 1'b0;
    for (int i = 0; i < 11; i++) m_taps[i] = 0;

    repeat (2) @(negedge clk);
    check("rst_awready", 32'(bif.awready), 32'd0);
    check("rst_arready", 32'(bif.arready), 32'd0);
    check("rst_rvalid", 32'(bif.rvalid), 32'd0);
    check("rst_rdata", bif.rdata, 32'd0);
    check("rst_ap_start", 32'(o_ap_start), 32'd0);
    check("rst_data_length", o_data_length, 32'd0);
    check("rst_tap_EN", 32'(o_tap_EN), 32'd0);
    check("rst_tap_WE", 32'(o_tap_WE), 32'd0);
    check("rst_irq", 32'(o_irq), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    fork compare_loop(); join_none

    axi_read(12'h000, 0, d);
    check("ctrl_after_reset", d, 32'h4);

    for (int i = 0; i < 11; i++) axi_write(12'(64 + 4*i), 32'(TAP_VALS[i]));
    for (int i = 0; i < 11; i++) begin
      axi_read(12'(64 + 4*i), 0, d);
      check($sformatf("tap%0d_readback", i), d, 32'(TAP_VALS[i]));
    end

    axi_write(12'h010, 32'd600);
    axi_read(12'h010, 0, d);
    check("len_600", d, 32'd600);
    axi_read(12'h000, 2, d);
    check("ctrl_idle", d, 32'h4);

    axi_write(12'h000, 32'h1);
    axi_read(12'h000, 0, d);
    check("ctrl_running", d, 32'h0);
    axi_write(12'h000, 32'h1);
    axi_write(12'h010, 32'd7);
    axi_write(12'h044, 32'h55);
    axi_read(12'h010, 0, d);
    check("len_locked", d, 32'd600);

    pulse_done();
    axi_read(12'h000, 0, d);
    check("ctrl_done", d, 32'h6);
    axi_read(12'h000, 0, d);
    check("ctrl_done_cleared", d, 32'h4);
    axi_read(12'h044, 0, d);
    check("tap1_kept", d, 32'hFFFFFFF6);

    axi_write(12'h020, 32'h1234);
    axi_read(12'h020, 0, d);
    check("unmapped_20", d, 32'h0);
    axi_read(12'h06C, 0, d);
    check("past_taps", d, 32'h0);

    axi_write(12'h004, 32'h1);
    axi_read(12'h004, 0, d);
    check("irq_en_reg", d, 32'(IRQ_ON));
    axi_write(12'h000, 32'h1);
    pulse_done();
    @(negedge clk);
    check("irq_on_done", 32'(o_irq), 32'(IRQ_ON));
    axi_read(12'h000, 0, d);
    check("ctrl_done_irq", d, 32'h6);
    @(negedge clk);
    check("irq_cleared", 32'(o_irq), 32'd0);

    fork
      axi_write(12'h048, 32'h77);
      begin
        @(posedge clk); #1;
        eng_tap_req = 1'b1; eng_tap_addr = 12'h00C;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          if (k == 2) eng_tap_req = 1'b0;
          else begin
            @(negedge clk);
            check("eng_tap_do", o_eng_tap_do, 32'd23);
          end
        end
        @(negedge clk);
        check("stall_wr_WE", 32'(o_tap_WE), 32'hF);
        check("stall_wr_A", 32'(o_tap_A), 32'h8);
        check("stall_wr_Di", o_tap_Di, 32'h77);
      end
    join
    axi_read(12'h048, 0, d);
    check("tap2_after_stall", d, 32'h77);
    axi_read(12'h04C, 0, d);
    check("tap3_untouched", d, 32'd23);

    @(posedge clk); #1;
    eng_tap_req = 1'b1; eng_tap_addr = 12'h000;
    bif.awaddr = 12'h050; bif.wdata = 32'hDEAD; bif.awvalid = 1'b1; bif.wvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    m_idle = 1'b1; m_done = 1'b0; m_len = '0; m_irq_en = 1'b0;
    #1;
    check("midrst_WE", 32'(o_tap_WE), 32'd0);
    check("midrst_awready", 32'(bif.awready), 32'd0);
    eng_tap_req = 1'b0; bif.awvalid = 1'b0; bif.wvalid = 1'b0;
    #1;
    check("midrst_EN", 32'(o_tap_EN), 32'd0);
    check("midrst_len", o_data_length, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(12'h050, 0, d);
    check("tap4_after_midrst", d, 32'd56);
    axi_read(12'h000, 0, d);
    check("ctrl_after_midrst", d, 32'h4);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
